// File: rtl/neuron_v3.sv
// rtl/neuron_v3.sv - streaming fixed-point neuron: saturating MAC, bias, round-half-even, clamp, optional ReLU
module neuron_v3 #(
    parameter int N   = 10,
    parameter int Q   = 9,
    parameter int G   = 4,
    parameter int ACT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic signed [N-1:0] w,
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sat,
    output logic                ovf
);
    localparam int A = 2*N + G;
    localparam int R = A - Q + 1;
    localparam logic signed [R-1:0] MAXR = R'(2**(N-1) - 1);
    localparam logic signed [R-1:0] MINR = ~MAXR;
    localparam logic signed [N-1:0] MAXO = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINO = {1'b1, {(N-1){1'b0}}};
    localparam logic [Q-1:0] HALF = {1'b1, {(Q-1){1'b0}}};

    typedef enum logic [1:0] {ACC, BIAS, RND, OUT} state_t;

    state_t                 state;
    logic signed [A-1:0]    acc;
    logic signed [N-1:0]    breg;
    logic signed [2*N-1:0]  prod;
    logic [A:0]             add_p;
    logic [A:0]             add_b;
    logic                   inc;
    logic signed [R-1:0]    rnd;
    logic signed [N-1:0]    res;
    logic                   res_sat;

    // Returns {clamped_flag, sum}; the sum is pinned to the signed limits instead of wrapping.
    function automatic logic [A:0] sadd(input logic [A-1:0] a, input logic [A-1:0] c);
        logic [A:0] s;
        s = {a[A-1], a} + {c[A-1], c};
        if (s[A] != s[A-1])
            return {1'b1, s[A], {(A-1){~s[A]}}};
        return {1'b0, s[A-1:0]};
    endfunction

    assign in_ready = (state == ACC);

    always_comb begin
        prod  = (2*N)'(w) * (2*N)'(x);
        add_p = sadd(acc, {{G{prod[2*N-1]}}, prod});
        add_b = sadd(acc, {{(A-N-Q){breg[N-1]}}, breg, {Q{1'b0}}});
        inc   = (acc[Q-1:0] > HALF) || ((acc[Q-1:0] == HALF) && acc[Q]);
        rnd   = $signed({acc[A-1], acc[A-1:Q]}) + $signed({{(R-1){1'b0}}, inc});
        res_sat = 1'b0;
        if (rnd > MAXR) begin
            res     = MAXO;
            res_sat = 1'b1;
        end else if (rnd < MINR) begin
            res     = MINO;
            res_sat = 1'b1;
        end else begin
            res = rnd[N-1:0];
        end
        if (ACT == 1 && res[N-1])
            res = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            breg      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ACC: if (in_valid) begin
                    acc <= add_p[A-1:0];
                    ovf <= ovf | add_p[A];
                    if (in_last) begin
                        breg  <= b;
                        state <= BIAS;
                    end
                end
                BIAS: begin
                    acc   <= add_b[A-1:0];
                    ovf   <= ovf | add_b[A];
                    state <= RND;
                end
                RND: begin
                    out       <= res;
                    sat       <= res_sat;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    ovf       <= 1'b0;
                    state     <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule
